// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-side types and AXI-lite constants
package mips_pkg;

   typedef enum logic [2:0] {
      START = 3'd0,
      ADDR  = 3'd1,
      DATA  = 3'd2,
      HOLD  = 3'd3,
      HALT  = 3'd4
   } fetch_state_t;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [2:0] AXI_PROT_INS  = 3'b100;
   localparam int         INS_BYTES     = 4;

endpackage

// File: rtl/ins_fetch_unit.sv
// rtl/ins_fetch_unit.sv - AXI-lite instruction fetch master with redirect handling
module ins_fetch_unit
   import mips_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 14,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   output logic [2:0]              m_arprot,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   output logic                    m_awvalid,
   output logic                    m_wvalid,
   output logic                    m_bready,
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic [2:0]              m_awprot,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    ins_valid,
   input  logic                    ins_ready,
   output logic [DATA_WIDTH-1:0]   ins_data,
   output logic [ADDR_WIDTH-1:0]   ins_pc,
   output logic                    ins_err,
   input  logic                    redirect_valid,
   input  logic [ADDR_WIDTH-1:0]   redirect_pc
);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                  discard_q, discard_d;
   logic [DATA_WIDTH-1:0] ins_data_q, ins_data_d;
   logic [ADDR_WIDTH-1:0] ins_pc_q, ins_pc_d;
   logic                  ins_err_q, ins_err_d;

   logic [ADDR_WIDTH-1:0] redir_pc;
   logic [ADDR_WIDTH-1:0] pc_inc;

   assign redir_pc = redirect_pc & ~ADDR_WIDTH'(3);
   assign pc_inc   = pc_q + ADDR_WIDTH'(INS_BYTES);

   // araddr is a separate register so a redirect arriving while AR is
   // pending can move pc without disturbing the address on the bus.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      araddr_d   = araddr_q;
      discard_d  = discard_q;
      ins_data_d = ins_data_q;
      ins_pc_d   = ins_pc_q;
      ins_err_d  = ins_err_q;
      case (state_q)
         START: begin
            state_d  = ADDR;
            pc_d     = redirect_valid ? redir_pc : pc_q;
            araddr_d = redirect_valid ? redir_pc : pc_q;
         end
         ADDR: begin
            if (redirect_valid) begin
               pc_d      = redir_pc;
               discard_d = 1'b1;
            end
            if (m_arready) state_d = DATA;
         end
         DATA: begin
            if (m_rvalid) begin
               if (discard_q || redirect_valid) begin
                  state_d   = ADDR;
                  discard_d = 1'b0;
                  pc_d      = redirect_valid ? redir_pc : pc_q;
                  araddr_d  = redirect_valid ? redir_pc : pc_q;
               end else begin
                  state_d    = HOLD;
                  ins_data_d = m_rdata;
                  ins_pc_d   = pc_q;
                  ins_err_d  = (m_rresp != AXI_RESP_OKAY);
               end
            end else if (redirect_valid) begin
               pc_d      = redir_pc;
               discard_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               state_d  = ADDR;
               pc_d     = redir_pc;
               araddr_d = redir_pc;
            end else if (ins_ready) begin
               if (ins_err_q) begin
                  state_d = HALT;
               end else begin
                  state_d  = ADDR;
                  pc_d     = pc_inc;
                  araddr_d = pc_inc;
               end
            end
         end
         HALT: begin
            if (redirect_valid) begin
               state_d  = ADDR;
               pc_d     = redir_pc;
               araddr_d = redir_pc;
            end
         end
         default: state_d = START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= START;
         pc_q       <= RESET_PC;
         araddr_q   <= RESET_PC;
         discard_q  <= 1'b0;
         ins_data_q <= '0;
         ins_pc_q   <= '0;
         ins_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         araddr_q   <= araddr_d;
         discard_q  <= discard_d;
         ins_data_q <= ins_data_d;
         ins_pc_q   <= ins_pc_d;
         ins_err_q  <= ins_err_d;
      end
   end

   assign m_araddr  = araddr_q;
   assign m_arprot  = AXI_PROT_INS;
   assign m_arvalid = (state_q == ADDR);
   assign m_rready  = (state_q == DATA);
   assign m_awvalid = 1'b0;
   assign m_wvalid  = 1'b0;
   assign m_bready  = 1'b1;
   assign m_awaddr  = '0;
   assign m_awprot  = '0;
   assign m_wdata   = '0;
   assign m_wstrb   = '0;
   assign ins_valid = (state_q == HOLD);
   assign ins_data  = ins_data_q;
   assign ins_pc    = ins_pc_q;
   assign ins_err   = ins_err_q;

endmodule
